// File: rtl/bcd_gray_sequencer_pkg.sv
// Shared types and constants for the multi-digit BCD-to-Gray sequencer.
package bcd_gray_sequencer_pkg;

    // Controller states: waiting for a word, converting digits, holding result.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CONV = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    localparam int unsigned DIGIT_W = 4;
    localparam logic [3:0]  BCD_MAX = 4'd9;

endpackage : bcd_gray_sequencer_pkg

// File: rtl/bcd_gray_sequencer_gray_digit_conv.sv
// Single-digit converter: 4-bit binary to Gray, plus a flag for values above 9.
module gray_digit_conv
    import bcd_gray_sequencer_pkg::*;
(
    input  logic [3:0] bcd_digit,
    output logic [3:0] gray_digit,
    output logic       invalid
);

    // Gray code is the value XORed with itself shifted right by one bit.
    always_comb begin
        gray_digit = bcd_digit ^ {1'b0, bcd_digit[3:1]};
        invalid    = (bcd_digit > BCD_MAX);
    end

endmodule : gray_digit_conv

// File: rtl/bcd_gray_sequencer.sv
// Multi-digit BCD-to-Gray controller: one shared digit converter is stepped
// across the captured word, LSD first, one digit per clock.
module bcd_gray_sequencer #(
    parameter int NUM_DIGITS = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [4*NUM_DIGITS-1:0] in_bcd,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [4*NUM_DIGITS-1:0] out_gray,
    output logic [NUM_DIGITS-1:0]   out_err,
    output logic                    busy,
    input  logic                    flush
);

    import bcd_gray_sequencer_pkg::*;

    localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int WORD_W = 4 * NUM_DIGITS;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

    seq_state_t              state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [WORD_W-1:0]       word_q, word_d;
    logic [WORD_W-1:0]       gray_q, gray_d;
    logic [NUM_DIGITS-1:0]   err_q, err_d;

    logic [3:0]              cur_digit;
    logic [3:0]              cur_gray;
    logic                    cur_invalid;

    // Select the digit addressed by the index from the captured word.
    always_comb begin
        cur_digit = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_digit = word_q[DIGIT_W*i +: DIGIT_W];
            end
        end
    end

    gray_digit_conv u_conv (
        .bcd_digit  (cur_digit),
        .gray_digit (cur_gray),
        .invalid    (cur_invalid)
    );

    // Next-state and datapath update; flush overrides every handshake.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        word_d  = word_q;
        gray_d  = gray_q;
        err_d   = err_q;
        if (flush) begin
            state_d = ST_IDLE;
            idx_d   = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        word_d  = in_bcd;
                        gray_d  = '0;
                        err_d   = '0;
                        idx_d   = '0;
                        state_d = ST_CONV;
                    end
                end
                ST_CONV: begin
                    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
                        if (idx_q == IDX_W'(i)) begin
                            gray_d[DIGIT_W*i +: DIGIT_W] = cur_gray;
                            err_d[i]                     = cur_invalid;
                        end
                    end
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            word_q  <= '0;
            gray_q  <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            gray_q  <= gray_d;
            err_q   <= err_d;
        end
    end

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign out_gray  = gray_q;
    assign out_err   = err_q;

endmodule : bcd_gray_sequencer

// File: tb/tb_bcd_gray_sequencer.sv
// Directed bench for bcd_gray_sequencer with hand-computed expected values.
module tb_bcd_gray_sequencer;

    localparam int ND = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   in_bcd;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_gray;
    logic [3:0]    out_err;
    logic          busy;
    logic          flush;

    int n_cmp;
    int n_bad;

    bcd_gray_sequencer #(.NUM_DIGITS(ND)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_bcd    (in_bcd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_gray  (out_gray),
        .out_err   (out_err),
        .busy      (busy),
        .flush     (flush)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count one comparison and report it when observed differs from expected.
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a word for one handshake edge (DUT assumed idle).
    task automatic send(input logic [15:0] word);
        in_bcd   = word;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
    endtask

    // Wait for out_valid with a bounded cycle budget; returns edges taken.
    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!out_valid && cycles < 20) begin
            tick();
            cycles++;
        end
    endtask

    // Return from DONE to IDLE with a single accepting edge.
    task automatic accept();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    int cyc;
    logic [15:0] held;

    initial begin
        n_cmp     = 0;
        n_bad     = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_bcd    = '0;
        out_ready = 1'b0;
        flush     = 1'b0;

        // Reset and idle
        tick();
        tick();
        check_eq("rst_in_ready",  in_ready,  1);
        check_eq("rst_out_valid", out_valid, 0);
        check_eq("rst_busy",      busy,      0);
        check_eq("rst_out_gray",  out_gray,  0);
        check_eq("rst_out_err",   out_err,   0);
        rst_n = 1'b1;
        tick();
        check_eq("idle_in_ready", in_ready, 1);

        // Valid word 0x1995 -> 0x1DD7
        send(16'h1995);
        check_eq("conv_busy",      busy,      1);
        check_eq("conv_in_ready",  in_ready,  0);
        check_eq("conv_out_valid", out_valid, 0);
        wait_done(cyc);
        check_eq("lat_1995",  cyc,      4);
        check_eq("gray_1995", out_gray, 16'h1DD7);
        check_eq("err_1995",  out_err,  4'b0000);
        accept();
        check_eq("ret_out_valid", out_valid, 0);
        check_eq("ret_in_ready",  in_ready,  1);
        check_eq("ret_busy",      busy,      0);
        check_eq("ret_gray_held", out_gray,  16'h1DD7);

        // Invalid digit 0x00A3 -> 0x00F2, err 0010; then backpressure
        send(16'h00A3);
        wait_done(cyc);
        check_eq("lat_00A3",  cyc,      4);
        check_eq("gray_00A3", out_gray, 16'h00F2);
        check_eq("err_00A3",  out_err,  4'b0010);
        held = out_gray;
        in_bcd = 16'h9999;
        for (int i = 0; i < 10; i++) begin
            in_valid = (i % 2 == 0);
            tick();
            check_eq("bp_out_valid", out_valid, 1);
            check_eq("bp_in_ready",  in_ready,  0);
            check_eq("bp_gray",      out_gray,  held);
            check_eq("bp_err",       out_err,   4'b0010);
        end
        in_valid = 1'b0;
        accept();
        check_eq("bp_ret_idle", in_ready, 1);

        // Several invalid digits 0xFB9A -> 0x8EDF, err 1101
        send(16'hFB9A);
        wait_done(cyc);
        check_eq("gray_FB9A", out_gray, 16'h8EDF);
        check_eq("err_FB9A",  out_err,  4'b1101);
        accept();

        // Flush mid-CONV after two digits
        send(16'h4321);
        tick();
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("flush_in_ready",  in_ready,  1);
        check_eq("flush_busy",      busy,      0);
        check_eq("flush_out_valid", out_valid, 0);
        for (int i = 0; i < 6; i++) begin
            tick();
            check_eq("flush_no_valid", out_valid, 0);
        end
        send(16'h0000);
        wait_done(cyc);
        check_eq("lat_0000",  cyc,      4);
        check_eq("gray_0000", out_gray, 16'h0000);
        check_eq("err_0000",  out_err,  4'b0000);
        accept();

        // Flush beats an input handshake in IDLE
        in_bcd   = 16'h1234;
        in_valid = 1'b1;
        flush    = 1'b1;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
        check_eq("flush_hs_busy",     busy,     0);
        check_eq("flush_hs_in_ready", in_ready, 1);

        // Async reset mid-DONE, no clock edge
        send(16'h1995);
        wait_done(cyc);
        check_eq("pre_rst_valid", out_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_out_valid", out_valid, 0);
        check_eq("arst_in_ready",  in_ready,  1);
        check_eq("arst_busy",      busy,      0);
        check_eq("arst_out_gray",  out_gray,  0);
        check_eq("arst_out_err",   out_err,   0);
        tick();
        rst_n = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_bcd_gray_sequencer
